// File: rtl/draw_rect_fall_ctl.sv
// Rectangle drop controller: follows the mouse, falls under gravity on a click, rests at the bottom.
// Optional bounce with velocity damping is enabled by defining DRAW_RECT_BOUNCE_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_FOLLOW | rectangle tracks mouse position every cycle
// S_FALL   | accelerating downward once per physics tick
// S_RISE   | rebounding upward after a damped impact (bounce builds only)
// S_REST   | parked at the bottom for REST_TICKS ticks or until a click
module draw_rect_fall_ctl #(
    parameter int W          = 12,
    parameter int VW         = 8,
    parameter int TICK_DIV   = 400000,
    parameter int G          = 1,
    parameter int YMAX       = 500,
    parameter int REST_TICKS = 100,
    parameter int DAMP_SHIFT = 1,
    parameter int VMIN       = 2
) (
    input  logic         clk40MHz,
    input  logic         rst_n,
    input  logic [W-1:0] mouse_xpos,
    input  logic [W-1:0] mouse_ypos,
    input  logic         mouse_left,
    output logic [W-1:0] xpos,
    output logic [W-1:0] ypos,
    output logic         busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (REST_TICKS > 1) ? $clog2(REST_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REST_LAST = RW'(REST_TICKS - 1);
    localparam logic [W-1:0]  YMAX_W    = W'(YMAX);
    localparam logic [W:0]    YMAX_W1   = (W+1)'(YMAX);
    localparam logic [VW:0]   G_V1      = (VW+1)'(G);
    localparam logic [VW:0]   VEL_SAT   = {1'b0, {VW{1'b1}}};

    typedef enum logic [1:0] {
        S_FOLLOW = 2'd0,
        S_FALL   = 2'd1,
`ifdef DRAW_RECT_BOUNCE_EN
        S_RISE   = 2'd2,
`endif
        S_REST   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  xpos_q, xpos_d;
    logic [W-1:0]  ypos_q, ypos_d;
    logic [VW-1:0] vel_q, vel_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [RW-1:0] rest_q, rest_d;
    logic          left_q;
    logic          busy_q;

    logic          tick;
    logic          click;
    logic [VW:0]   vel_inc;
    logic [VW-1:0] vel_n;
    logic [W:0]    fall_sum;

    assign tick     = (tick_q == TICK_LAST);
    assign click    = mouse_left & ~left_q;
    assign vel_inc  = {1'b0, vel_q} + G_V1;
    assign vel_n    = (vel_inc > VEL_SAT) ? {VW{1'b1}} : vel_inc[VW-1:0];
    assign fall_sum = {1'b0, ypos_q} + (W+1)'(vel_n);

`ifdef DRAW_RECT_BOUNCE_EN
    localparam logic [VW-1:0] G_V    = VW'(G);
    localparam logic [VW-1:0] VMIN_V = VW'(VMIN);

    logic [VW-1:0] vel_bnc;
    logic [VW-1:0] vel_dec;
    logic [W-1:0]  rise_y;

    assign vel_bnc = vel_n - (vel_n >> DAMP_SHIFT);
    assign vel_dec = (vel_q > G_V) ? (vel_q - G_V) : '0;
    // Upward motion clamps at the top edge instead of wrapping
    assign rise_y  = ({1'b0, ypos_q} >= (W+1)'(vel_q)) ? (ypos_q - W'(vel_q)) : '0;
`endif

    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        vel_d   = vel_q;
        rest_d  = rest_q;
        tick_d  = tick ? '0 : (tick_q + TW'(1));

        case (state_q)
            S_FOLLOW: begin
                xpos_d = mouse_xpos;
                ypos_d = mouse_ypos;
                if (click) begin
                    vel_d  = '0;
                    tick_d = '0;
                    if (mouse_ypos >= YMAX_W) begin
                        ypos_d  = YMAX_W;
                        rest_d  = '0;
                        state_d = S_REST;
                    end else begin
                        state_d = S_FALL;
                    end
                end
            end
            S_FALL: begin
                if (tick) begin
                    if (fall_sum >= YMAX_W1) begin
                        ypos_d = YMAX_W;
                        rest_d = '0;
`ifdef DRAW_RECT_BOUNCE_EN
                        if (vel_bnc < VMIN_V) begin
                            vel_d   = '0;
                            state_d = S_REST;
                        end else begin
                            vel_d   = vel_bnc;
                            state_d = S_RISE;
                        end
`else
                        vel_d   = '0;
                        state_d = S_REST;
`endif
                    end else begin
                        ypos_d = fall_sum[W-1:0];
                        vel_d  = vel_n;
                    end
                end
            end
`ifdef DRAW_RECT_BOUNCE_EN
            S_RISE: begin
                if (tick) begin
                    ypos_d = rise_y;
                    if (vel_dec <= G_V) begin
                        vel_d   = '0;
                        state_d = S_FALL;
                    end else begin
                        vel_d = vel_dec;
                    end
                end
            end
`endif
            S_REST: begin
                // A click here only releases the rectangle; left_q blocks a second drop
                if (click) begin
                    state_d = S_FOLLOW;
                end else if (tick) begin
                    if (rest_q == REST_LAST) begin
                        rest_d  = '0;
                        state_d = S_FOLLOW;
                    end else begin
                        rest_d = rest_q + RW'(1);
                    end
                end
            end
            default: state_d = S_FOLLOW;
        endcase
    end

    always_ff @(posedge clk40MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FOLLOW;
            xpos_q  <= '0;
            ypos_q  <= '0;
            vel_q   <= '0;
            tick_q  <= '0;
            rest_q  <= '0;
            left_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            vel_q   <= vel_d;
            tick_q  <= tick_d;
            rest_q  <= rest_d;
            left_q  <= mouse_left;
            busy_q  <= (state_d != S_FOLLOW);
        end
    end

    assign xpos = xpos_q;
    assign ypos = ypos_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_draw_rect_fall_ctl.sv
// Directed scoreboard bench for draw_rect_fall_ctl with a small tick-level physics model.
// Bounce expectations follow DRAW_RECT_BOUNCE_EN when it is defined for the build.
module tb_draw_rect_fall_ctl;

    localparam int W = 12;
`ifdef DRAW_RECT_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic         clk40MHz = 1'b0;
    logic         rst_n    = 1'b0;
    logic [W-1:0] mouse_xpos = '0;
    logic [W-1:0] mouse_ypos = '0;
    logic         mouse_left = 1'b0;
    logic [W-1:0] xpos;
    logic [W-1:0] ypos;
    logic         busy;

    always #5 clk40MHz = ~clk40MHz;

    draw_rect_fall_ctl #(
        .W(12), .VW(8), .TICK_DIV(4), .G(1), .YMAX(500),
        .REST_TICKS(8), .DAMP_SHIFT(1), .VMIN(2)
    ) dut (
        .clk40MHz   (clk40MHz),
        .rst_n      (rst_n),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .xpos       (xpos),
        .ypos       (ypos),
        .busy       (busy)
    );

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         b;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic push(input string tag, input int x, input int y, input bit b);
        exp_t e;
        e.x = W'(x);
        e.y = W'(y);
        e.b = b;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check();
        exp_t  e;
        string tag;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=(%0d,%0d,%0b)", xpos, ypos, busy);
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (xpos === e.x && ypos === e.y && busy === e.b) else begin
                bad++;
                $error("FAIL %s observed=(%0d,%0d,%0b) expected=(%0d,%0d,%0b)",
                       tag, xpos, ypos, busy, e.x, e.y, e.b);
            end
        end
    endtask

    task automatic chk_y(input string tag, input int y);
        total++;
        assert (ypos === W'(y)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, ypos, y);
        end
    endtask

    task automatic step();
        @(posedge clk40MHz);
        #1;
    endtask

    initial begin
        int y, v, st, ticks;
        int coords_x[4];
        int coords_y[4];
        coords_x = '{5, 4095, 0, 1234};
        coords_y = '{17, 0, 4095, 499};

        // Reset state
        #12;
        push("reset_state", 0, 0, 0);
        check();
        mouse_xpos = 12'd7;
        mouse_ypos = 12'd9;
        #1 rst_n = 1'b1;
        step();
        push("follow_after_release", 7, 9, 0);
        check();

        // Follow with one cycle of latency
        for (int i = 0; i < 4; i++) begin
            mouse_xpos = W'(coords_x[i]);
            mouse_ypos = W'(coords_y[i]);
            #1;
            push("follow_latency_hold", (i == 0) ? 7 : coords_x[i-1], (i == 0) ? 9 : coords_y[i-1], 0);
            check();
            step();
            push("follow_track", coords_x[i], coords_y[i], 0);
            check();
        end

        // Drop from (100,0); mouse wanders away, extra click during FALL
        mouse_xpos = 12'd100;
        mouse_ypos = 12'd0;
        step();
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
        push("drop_latch", 100, 0, 1);
        check();
        mouse_xpos = 12'd300;
        mouse_ypos = 12'd50;
        y = 0; v = 0; st = 1; ticks = 0;
        while (st != 3 && ticks < 400) begin
            ticks++;
            for (int s = 0; s < 4; s++) begin
                mouse_left = (ticks == 5 && s == 0) ? 1'b1 : 1'b0;
                step();
                if (s < 3) begin
                    push("drop_between_ticks", 100, y, 1);
                    check();
                end
            end
            mouse_left = 1'b0;
            if (st == 1) begin
                v = (v + 1 > 255) ? 255 : v + 1;
                if (y + v >= 500) begin
                    y = 500;
                    if (BOUNCE) begin
                        v = v - (v >> 1);
                        st = (v < 2) ? 3 : 2;
                        if (st == 3) v = 0;
                    end else begin
                        st = 3;
                    end
                end else begin
                    y = y + v;
                end
            end else begin
                y = (y >= v) ? y - v : 0;
                v = (v > 1) ? v - 1 : 0;
                if (v <= 1) begin
                    v = 0;
                    st = 1;
                end
            end
            push("drop_tick", 100, y, 1);
            check();
            if (ticks == 31) chk_y("tick31_ypos", 496);
            if (ticks == 32) chk_y("tick32_clamped", 500);
        end
        total++;
        assert (st == 3) else begin
            bad++;
            $error("FAIL drop_no_rest observed_ticks=%0d expected_rest_within=400", ticks);
        end

        // REST for 8 ticks, then back to FOLLOW
        for (int r = 0; r < 32; r++) begin
            step();
            push("rest_hold", 100, 500, (r < 31) ? 1'b1 : 1'b0);
            check();
        end
        step();
        push("follow_after_rest", 300, 50, 0);
        check();

        // Click below YMAX goes straight to REST; click in REST releases without a new drop
        mouse_xpos = 12'd40;
        mouse_ypos = 12'd550;
        step();
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
        push("direct_rest", 40, 500, 1);
        check();
        for (int r = 0; r < 3; r++) begin
            step();
            push("direct_rest_hold", 40, 500, 1);
            check();
        end
        mouse_left = 1'b1;
        step();
        push("rest_click_release", 40, 500, 0);
        check();
        step();
        push("rest_click_no_drop", 40, 550, 0);
        check();
        mouse_left = 1'b0;
        step();
        push("follow_after_click", 40, 550, 0);
        check();

        // Reset in the middle of a fall
        mouse_xpos = 12'd100;
        mouse_ypos = 12'd0;
        step();
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
        repeat (12) step();
        push("midfall_before_reset", 100, 6, 1);
        check();
        #3 rst_n = 1'b0;
        #1;
        push("async_reset", 0, 0, 0);
        check();
        mouse_xpos = 12'd100;
        mouse_ypos = 12'd200;
        #2 rst_n = 1'b1;
        step();
        push("track_after_reset", 100, 200, 0);
        check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_rect_fall_ctl.md
DRAW_RECT_FALL_CTL -- requirements
Module: draw_rect_fall_ctl

Interface
REQ-001 Parameter W, default 12: coordinate width.
REQ-002 Parameter VW, default 8: velocity width, unsigned.
REQ-003 Parameter TICK_DIV, default 400000: clock cycles per physics tick (10 ms at 40 MHz).
REQ-004 Parameter G, default 1: velocity increment per tick.
REQ-005 Parameter YMAX, default 500: landing ypos (screen bottom minus rectangle height).
REQ-006 Parameter REST_TICKS, default 100: ticks held at bottom before returning to mouse.
REQ-007 Parameter DAMP_SHIFT, default 1, and VMIN, default 2: bounce damping and stop threshold.
REQ-008 clk40MHz  in  1  sole clock; all logic on its rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 mouse_xpos  in  W  mouse x coordinate.
REQ-011 mouse_ypos  in  W  mouse y coordinate.
REQ-012 mouse_left  in  1  left button level.
REQ-013 xpos  out  W  rectangle x, registered.
REQ-014 ypos  out  W  rectangle y, registered.
REQ-015 busy  out  1  high in FALL, RISE or REST.

Function
REQ-016 States: FOLLOW, FALL, RISE, REST.
REQ-017 Click = mouse_left high while its 1-cycle registered copy is low; only a click starts a drop.
REQ-018 FOLLOW: xpos/ypos <= mouse_xpos/mouse_ypos each cycle (1-cycle latency).
REQ-019 Click in FOLLOW: latch xpos=mouse_xpos, ypos=mouse_ypos, vel=0, clear tick counter, enter FALL.
REQ-020 Click in FOLLOW with mouse_ypos >= YMAX: ypos=YMAX, enter REST directly.
REQ-021 Tick counter counts 0..TICK_DIV-1 and wraps; tick pulses for one cycle at TICK_DIV-1.
REQ-022 xpos holds its latched value in FALL, RISE and REST.
REQ-023 FALL, per tick: vel_n = min(vel+G, 2^VW-1); ypos += vel_n, sums computed in W+1 bits.
REQ-024 FALL, per tick, sum >= YMAX: ypos=YMAX (landing).
REQ-025 Landing without bounce: enter REST.
REQ-026 Landing with bounce: vel = vel_n - (vel_n >> DAMP_SHIFT); vel < VMIN -> REST, else RISE.
REQ-027 RISE, per tick: ypos -= vel, saturating at 0; vel -= G.
REQ-028 RISE, vel <= G after update: enter FALL with vel=0.
REQ-029 REST: count ticks; on REST_TICKS ticks or a click, enter FOLLOW; the click does not start a new drop.
REQ-030 Clicks in FALL and RISE are ignored.
REQ-031 busy is registered and changes on the same edge as the state.

Reset
REQ-032 rst_n low immediately forces state FOLLOW; xpos, ypos, vel, tick counter, rest counter and click register = 0; busy = 0.
REQ-033 Reset mid-drop discards motion; after release, outputs track the mouse from the first edge.

Configuration
REQ-034 Macro DRAW_RECT_BOUNCE_EN defined: REQ-026/027/028 active; the RISE state exists.
REQ-035 DRAW_RECT_BOUNCE_EN undefined: RISE and damping logic are absent; landing always enters REST.

Verification (TICK_DIV=4, G=1, YMAX=500, REST_TICKS=8, DAMP_SHIFT=1, VMIN=2)
REQ-036 Assert rst_n=0 mid-FALL -> xpos=ypos=0, busy=0 without a clock edge; release with mouse at (100,200) -> (100,200) one cycle later.
REQ-037 Click at (100,0), mouse then moves -> xpos stays 100; after k ticks ypos=k(k+1)/2; tick 31 gives 496, tick 32 gives 500 (clamped).
REQ-038 No bounce, after landing -> ypos=500 for 8 ticks, then FOLLOW, busy=0, ypos=mouse_ypos next cycle.
REQ-039 Bounce enabled, impact vel 32 -> vel 16, RISE; ypos decreases by 16, 15, ...; FALL re-entered; repeats until vel < 2, then REST.
REQ-040 Click with mouse_ypos=550 -> ypos=500, REST directly; click during FALL -> no change; click in REST -> FOLLOW the next cycle.
